// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver with receive FIFO: the frame FSM
// state encoding, the idle line level and the data-bit count.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state).
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam logic        IDLE_LEVEL = 1'b1;
   localparam int unsigned DATA_BITS  = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
`ifdef UART_RX_PARITY_EN
      ,
      PARITY    = 3'd5
`endif
   } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_if
// Consumer-side bundle of uart_rx_fifo: received-byte stream and error flags.
//   dout       : FIFO head byte (don't-care while dout_valid is low)
//   dout_valid : FIFO non-empty
//   dout_ready : consumer pops the head when dout_valid && dout_ready
//   fifo_count : current occupancy, $clog2(FIFO_DEPTH)+1 bits
//   overflow   : sticky, a received byte was dropped
//   frame_err  : sticky, bad stop bit (or bad parity)
//   err_clr    : one-cycle pulse clearing both sticky flags
// Modports: master = receiver side, slave = consumer side.
// -----------------------------------------------------------------------------
interface uart_rx_fifo_if #(
   parameter int FIFO_DEPTH = 8
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]    dout;
   logic          dout_valid;
   logic          dout_ready;
   logic [CW-1:0] fifo_count;
   logic          overflow;
   logic          frame_err;
   logic          err_clr;

   modport master (
      output dout, dout_valid, fifo_count, overflow, frame_err,
      input  dout_ready, err_clr
   );

   modport slave (
      input  dout, dout_valid, fifo_count, overflow, frame_err,
      output dout_ready, err_clr
   );

endinterface

// File: rtl/rx_fifo.sv
// -----------------------------------------------------------------------------
// rx_fifo
// Byte FIFO with FIFO_DEPTH entries (power of two); pointers wrap naturally.
//   clk, rst_n : clock, async active-low reset
//   i_push     : write i_data (accepted when not full, or full with a pop)
//   i_pop      : remove head (ignored when empty)
//   i_data     : write data
//   o_data     : head entry, read combinationally from storage
//   o_full     : FIFO_DEPTH entries held
//   o_empty    : no entries held
//   o_count    : occupancy
// -----------------------------------------------------------------------------
module rx_fifo #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          i_push,
   input  logic                          i_pop,
   input  logic [7:0]                    i_data,
   output logic [7:0]                    o_data,
   output logic                          o_full,
   output logic                          o_empty,
   output logic [$clog2(FIFO_DEPTH):0]   o_count
);
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_wr_en;
   logic          w_rd_en;

   assign o_full  = (r_count == (AW+1)'(FIFO_DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];

   // A full FIFO can still take a byte when the head leaves in the same cycle.
   assign w_wr_en = i_push && (!o_full || i_pop);
   assign w_rd_en = i_pop && !o_empty;

   // NOTE: storage has no reset; the pointers alone define what is valid, and a
   // resettable memory would block RAM inference for no functional gain.
   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_wr_en, w_rd_en})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN defined) feeding a byte
// FIFO, with sticky overflow and framing-error flags.
//   clk    : clock, all state on rising edge
//   rst_n  : async active-low reset
//   rx_i   : serial line, idle high, asynchronous to clk
//   bus    : uart_rx_fifo_if.master (dout, dout_valid, dout_ready, fifo_count,
//            overflow, frame_err, err_clr)
// Parameters: CLKS_PER_BIT (even, >= 4), FIFO_DEPTH (power of two, 2..64).
// Optional macro: UART_RX_PARITY_EN.
// -----------------------------------------------------------------------------
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rx_i,
   uart_rx_fifo_if.master bus
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);

   logic [1:0]       r_sync;
   logic             w_rx;
   rx_state_e        r_state,   w_state_nxt;
   logic [CNT_W-1:0] r_clk_cnt, w_clk_cnt_nxt;
   logic [2:0]       r_bit_cnt, w_bit_cnt_nxt;
   logic [7:0]       r_shift,   w_shift_nxt;
   logic             w_push;
   logic             w_ferr_set;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic             w_drop;
   logic             w_half_tick;
   logic             w_bit_tick;
   logic             r_overflow;
   logic             r_frame_err;

   // Synchronizer flops reset to the idle level so reset never fakes a start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sync <= {2{IDLE_LEVEL}};
      else        r_sync <= {r_sync[0], rx_i};
   end
   assign w_rx = r_sync[1];

   assign w_half_tick = (r_clk_cnt == CNT_W'(CLKS_PER_BIT/2 - 1));
   assign w_bit_tick  = (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_clk_cnt <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_clk_cnt <= w_clk_cnt_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_shift   <= w_shift_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt   = r_state;
      w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
      w_bit_cnt_nxt = r_bit_cnt;
      w_shift_nxt   = r_shift;
      w_push        = 1'b0;
      w_ferr_set    = 1'b0;
      case (r_state)
         IDLE: begin
            w_clk_cnt_nxt = '0;
            w_bit_cnt_nxt = '0;
            if (w_rx != IDLE_LEVEL) w_state_nxt = START;
         end
         START: begin
            if (w_half_tick) begin
               w_clk_cnt_nxt = '0;
               // A line already back high at mid start bit was a glitch.
               w_state_nxt   = (w_rx == IDLE_LEVEL) ? IDLE : DATA;
            end
         end
         DATA: begin
            if (w_bit_tick) begin
               w_clk_cnt_nxt = '0;
               w_shift_nxt   = {w_rx, r_shift[7:1]};
               w_bit_cnt_nxt = r_bit_cnt + 3'd1;
               if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                  w_state_nxt = PARITY;
`else
                  w_state_nxt = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (w_bit_tick) begin
               w_clk_cnt_nxt = '0;
               // Even parity: data plus parity bit carry an even number of ones.
               if (w_rx != ^r_shift) begin
                  w_ferr_set  = 1'b1;
                  w_state_nxt = WAIT_IDLE;
               end else begin
                  w_state_nxt = STOP;
               end
            end
         end
`endif
         STOP: begin
            if (w_bit_tick) begin
               w_clk_cnt_nxt = '0;
               if (w_rx == IDLE_LEVEL) begin
                  w_push      = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_ferr_set  = 1'b1;
                  w_state_nxt = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            w_clk_cnt_nxt = '0;
            if (w_rx == IDLE_LEVEL) w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign w_pop  = bus.dout_ready && !w_empty;
   assign w_drop = w_push && w_full && !w_pop;

   rx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_rx_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (r_shift),
      .o_data  (bus.dout),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (bus.fifo_count)
   );

   // Sticky flags: a new event in the same cycle as err_clr wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         if (w_drop)           r_overflow  <= 1'b1;
         else if (bus.err_clr) r_overflow  <= 1'b0;
         if (w_ferr_set)       r_frame_err <= 1'b1;
         else if (bus.err_clr) r_frame_err <= 1'b0;
      end
   end

   assign bus.dout_valid = !w_empty;
   assign bus.overflow   = r_overflow;
   assign bus.frame_err  = r_frame_err;

endmodule
